// File: rtl/pid_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pid_pkg: shared types and default constants for PID and PWM blocks.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package pid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        RUN  = 2'd2
    } pwm_state_t;

    localparam int PERIOD   = 1000;
    localparam int U_MAX    = 1000;
    localparam int DEADTIME = 4;

endpackage
`default_nettype wire

// File: rtl/pwm_clamp.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_clamp: symmetric clamp of a signed effort to +/-U_MAX, then       |
// | magnitude, sign and saturation flag. Purely combinational.            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pwm_clamp #(
    parameter int W     = 15,
    parameter int CNT_W = 10,
    parameter int U_MAX = pid_pkg::U_MAX
) (
    input  logic signed [W:0]     u_in,
    output logic        [CNT_W:0] mag,
    output logic                  dir,
    output logic                  sat
);

    // One extra bit so that -U_MAX and the negation below never overflow.
    localparam logic signed [W+1:0] C_POS = (W+2)'(U_MAX);
    localparam logic signed [W+1:0] C_NEG = -C_POS;

    logic signed [W+1:0] w_ext;
    logic signed [W+1:0] w_uc;
    logic signed [W+1:0] w_abs;

    always_comb begin
        w_ext = {u_in[W], u_in};
        if (w_ext > C_POS) begin
            w_uc = C_POS;
        end else if (w_ext < C_NEG) begin
            w_uc = C_NEG;
        end else begin
            w_uc = w_ext;
        end
        w_abs = w_uc[W+1] ? -w_uc : w_uc;
        mag   = (CNT_W+1)'(w_abs);
        dir   = w_uc[W+1];
        sat   = (w_uc != w_ext);
    end

endmodule
`default_nettype wire

// File: rtl/pwm_bridge_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_bridge_driver: sign/magnitude edge-aligned H-bridge PWM with      |
// | double-buffered duty and dead-time on direction reversal.             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module pwm_bridge_driver #(
    parameter int W        = 15,
    parameter int CNT_W    = 10,
    parameter int PERIOD   = pid_pkg::PERIOD,
    parameter int U_MAX    = pid_pkg::U_MAX,
    parameter int DEADTIME = pid_pkg::DEADTIME
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [W:0] u_in,
    output logic              pwm_a,
    output logic              pwm_b,
    output logic              dir,
    output logic              sat,
    output logic              period_tick
);

    import pid_pkg::*;

    localparam int               DUTY_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W:0]    w_mag;
    logic              w_dir;
    logic              w_sat;
    logic [DUTY_W-1:0] w_duty;

    pwm_clamp #(
        .W     (W),
        .CNT_W (CNT_W),
        .U_MAX (U_MAX)
    ) u_clamp (
        .u_in (u_in),
        .mag  (w_mag),
        .dir  (w_dir),
        .sat  (w_sat)
    );

    // Map |effort| onto counts so that U_MAX always means a full period.
    generate
        if (PERIOD == U_MAX) begin : g_unity
            assign w_duty = w_mag;
        end else begin : g_scale
            localparam int PROD_W = 2 * CNT_W + 2;
            logic [PROD_W-1:0] w_prod;
            assign w_prod = (PROD_W'(w_mag) * PROD_W'(PERIOD)) / PROD_W'(U_MAX);
            assign w_duty = DUTY_W'(w_prod);
        end
    endgenerate

    pwm_state_t        r_state;
    pwm_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_dead_cnt;
    logic [DUTY_W-1:0] r_duty_sh;
    logic              r_dir_sh;
    logic              r_sat_sh;
    logic              w_boundary;
    logic              w_dead_done;
    logic              w_active;

    assign w_boundary  = (r_cnt == C_LAST) && (r_state != IDLE);
    assign w_dead_done = (int'(r_dead_cnt) == DEADTIME - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    if (DEADTIME == 0) begin
                        w_next = RUN;
                    end else begin
                        w_next = DEAD;
                    end
                end
            end
            DEAD: begin
                if (!enable) begin
                    w_next = IDLE;
                end else if (w_dead_done) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    w_next = IDLE;
                end else if (w_boundary && (w_dir != r_dir_sh) && (DEADTIME > 0)) begin
                    w_next = DEAD;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Counter wraps on the last count and is forced to 0 whenever the
    // next state is (or stays) IDLE, so every start is at cnt = 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_dead_cnt <= '0;
            r_duty_sh  <= '0;
            r_dir_sh   <= 1'b0;
            r_sat_sh   <= 1'b0;
        end else begin
            if ((r_state == IDLE) || !enable || (r_cnt == C_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == DEAD) begin
                r_dead_cnt <= r_dead_cnt + CNT_W'(1);
            end else begin
                r_dead_cnt <= '0;
            end

            if ((r_state == IDLE) || w_boundary) begin
                r_duty_sh <= w_duty;
                r_dir_sh  <= w_dir;
                r_sat_sh  <= w_sat;
            end
        end
    end

    always_comb begin
        w_active    = (r_state == RUN) && ({1'b0, r_cnt} < r_duty_sh);
        pwm_a       = w_active && !r_dir_sh;
        pwm_b       = w_active && r_dir_sh;
        period_tick = w_boundary;
        dir         = r_dir_sh;
        sat         = r_sat_sh;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_bridge_driver.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pwm_bridge_driver: directed test of pwm_bridge_driver with         |
// | PERIOD=10, U_MAX=10, DEADTIME=2, CNT_W=4.                             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_pwm_bridge_driver;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] u_in;
    logic               pwm_a;
    logic               pwm_b;
    logic               dir;
    logic               sat;
    logic               period_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_bridge_driver #(
        .W        (15),
        .CNT_W    (4),
        .PERIOD   (10),
        .U_MAX    (10),
        .DEADTIME (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .u_in        (u_in),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .dir         (dir),
        .sat         (sat),
        .period_tick (period_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected vector order: {pwm_a, pwm_b, period_tick, dir, sat}
    task automatic check_now(input string tag, input logic [4:0] exp_v);
        logic [4:0] obs;
        obs = {pwm_a, pwm_b, period_tick, dir, sat};
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Checks one full period starting at cnt=0; bit i of a mask is cnt i.
    task automatic check_period(input string tag, input logic [9:0] am,
                                input logic [9:0] bm, input logic d, input logic s);
        for (int i = 0; i < 10; i++) begin
            check_now($sformatf("%s[%0d]", tag, i), {am[i], bm[i], (i == 9), d, s});
            @(negedge clk);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        u_in   = 16'sd0;
        @(negedge clk);
        check_now("reset", 5'b00000);

        // Reset must dominate enable and the IDLE shadow load.
        enable = 1'b1;
        u_in   = -16'sd5;
        @(negedge clk);
        check_now("reset_prio", 5'b00000);

        reset = 1'b0;
        u_in  = 16'sd4;
        @(negedge clk);
        check_period("start_p1", 10'h00C, 10'h000, 1'b0, 1'b0);
        check_period("start_p2", 10'h00F, 10'h000, 1'b0, 1'b0);

        u_in = 16'sd25;
        check_period("sat_hold", 10'h00F, 10'h000, 1'b0, 1'b0);
        check_period("sat_pos", 10'h3FF, 10'h000, 1'b0, 1'b1);

        u_in = -16'sd32768;
        check_period("sat_pos2", 10'h3FF, 10'h000, 1'b0, 1'b1);
        check_period("sat_neg_dead", 10'h000, 10'h3FC, 1'b1, 1'b1);
        check_period("sat_neg", 10'h000, 10'h3FF, 1'b1, 1'b1);

        u_in = 16'sd6;
        check_period("neg_hold", 10'h000, 10'h3FF, 1'b1, 1'b1);
        check_period("fwd6_dead", 10'h03C, 10'h000, 1'b0, 1'b0);

        // Change direction mid-period; the current frame must not notice.
        for (int i = 0; i < 10; i++) begin
            check_now($sformatf("rev_cur[%0d]", i), {(i < 6), 1'b0, (i == 9), 1'b0, 1'b0});
            if (i == 5) u_in = -16'sd3;
            @(negedge clk);
        end
        u_in = 16'sd0;
        check_period("rev_next", 10'h000, 10'h004, 1'b1, 1'b0);

        u_in = 16'sd5;
        check_period("zero", 10'h000, 10'h000, 1'b0, 1'b0);
        check_period("same_dir", 10'h01F, 10'h000, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            check_now($sformatf("pre_drop[%0d]", i), {(i < 5), 1'b0, 1'b0, 1'b0, 1'b0});
            if (i == 5) enable = 1'b0;
            @(negedge clk);
        end
        check_now("drop_idle", 5'b00000);
        u_in = -16'sd7;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check_now($sformatf("idle_track[%0d]", i), 5'b00010);
        end

        u_in   = 16'sd5;
        enable = 1'b1;
        @(negedge clk);
        check_period("reen_dead", 10'h01C, 10'h000, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            check_now($sformatf("pre_rst[%0d]", i), {(i < 5), 1'b0, 1'b0, 1'b0, 1'b0});
            if (i == 7) begin
                reset = 1'b1;
                u_in  = 16'sd8;
            end
            @(negedge clk);
        end
        check_now("rst_mid", 5'b00000);
        reset = 1'b0;
        @(negedge clk);
        check_period("post_rst_dead", 10'h0FC, 10'h000, 1'b0, 1'b0);
        check_period("post_rst_run", 10'h0FF, 10'h000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_bridge_driver.md
# pwm_bridge_driver

Downstream actuator stage for the PID controller. Consumes the signed control effort `u_out` and clamps it to a programmable magnitude. Converts it into a sign/magnitude, double-buffered, edge-aligned PWM pair for an H-bridge, with dead-time inserted on every direction reversal. Emits a once-per-period tick so upstream logic can align error sampling to the PWM frame.

## Interface
- `W`, 15: effort MSB index; effort is `W+1` bits, two's complement (matches PID).
- `CNT_W`, 10: period counter width.
- `PERIOD`, 1000: PWM period in clk cycles. Constraint: 2 ≤ PERIOD ≤ 2^CNT_W.
- `U_MAX`, 1000: clamp magnitude. Constraint: 1 ≤ U_MAX ≤ PERIOD. Effort `U_MAX` gives 100 % duty.
- `DEADTIME`, 4: cycles both legs are forced low after a reversal. Constraint: 0 ≤ DEADTIME < PERIOD.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: run request.
- `u_in`, in, signed [W:0]: control effort; connected to PID `u_out`.
- `pwm_a`, out, 1: forward leg drive.
- `pwm_b`, out, 1: reverse leg drive.
- `dir`, out, 1: latched direction; 1 = reverse.
- `sat`, out, 1: latched effort was clamped.
- `period_tick`, out, 1: one-cycle pulse on the last count of each period.

## Operation
- **Clamp:**
  - u_c = min(max(u_in, −U_MAX), U_MAX).
  - mag = |u_c| (fits CNT_W+1 bits). Clamping happens before abs, so −2^W cannot overflow.
  - Direction is the sign bit of u_c; zero effort gives dir 0.
  - sat_next = (u_in ≠ u_c).
- **Shadow registers:**
  - duty_sh, dir_sh and sat_sh load from the clamp only at frame boundaries, i.e. the cycle where cnt == PERIOD−1 in RUN/DEAD.
  - In IDLE they load every cycle.
  - Mid-period changes to `u_in` never affect the current period.
- **Counter:**
  - cnt runs 0..PERIOD−1, then wraps to 0.
  - Held at 0 in IDLE.
- **FSM states:** IDLE, DEAD, RUN.
  - IDLE → DEAD when `enable`=1. If DEADTIME=0, go straight to RUN.
  - DEAD → RUN when dead counter reaches DEADTIME−1. Dead counter starts at 0 on entry.
  - RUN → DEAD at a frame boundary if the newly loaded dir_sh differs from the old dir_sh and DEADTIME > 0. Otherwise stay in RUN.
  - Any state → IDLE when `enable`=0, effective next cycle.
  - Entry into DEAD always coincides with cnt=0.
- **Output decode:** from registers only; no combinational path from `u_in`.
  - active = (cnt < duty_sh) && state==RUN.
  - pwm_a = active && !dir_sh; pwm_b = active && dir_sh.
  - In DEAD and IDLE both legs are 0. pwm_a and pwm_b are never 1 together.
  - Dead-time eats into the pulse: the pulse is not shifted.
- **Other outputs:** `dir` = dir_sh, `sat` = sat_sh. `period_tick` = (cnt == PERIOD−1) && state != IDLE.

## Timing
- **Reset:** state IDLE, cnt 0, shadows 0. `pwm_a`, `pwm_b`, `dir`, `sat` and `period_tick` are all 0 in the cycle after reset is sampled high.
- **Reset mid-period:** same result as above. Reset has priority over `enable`.
- **Input-to-output latency:** a `u_in` value sampled at a boundary edge takes effect from cnt=0 of the next period, one cycle later.
- **Start-up:** after `enable` rises in IDLE, first cycle has cnt=0 in DEAD (or RUN if DEADTIME=0). The first period always begins with dead-time.
- **Duty limits:** duty_sh = 0 gives both legs low all period. duty_sh = PERIOD gives the leg high all period.
- **Boundary plus enable drop:** if the boundary and `enable`=0 coincide, the disable wins. Next cycle is IDLE and no tick occurs while in IDLE.

## Structure
- Shared package `pid_pkg` holds:
  - the state enum `pwm_state_t` {IDLE, DEAD, RUN};
  - the default constants PERIOD, U_MAX and DEADTIME, used by both the PID and this block.
- One natural sub-module, `pwm_clamp`: purely combinational clamp, abs and sign. Inputs `u_in`, `U_MAX`; outputs mag, dir, sat. Reusable for PID anti-windup.
- Top level holds the counter, dead counter, shadow registers and FSM.

## Test plan
All scenarios use PERIOD=10, U_MAX=10, DEADTIME=2, CNT_W=4.
- **Start-up:** reset, then enable=1, u_in=4.
  - First period: cnt0–1 both legs low; cnt2–3 pwm_a=1; cnt4–9 low.
  - Next period: pwm_a=1 for cnt0–3.
  - period_tick every 10 cycles; sat=0, dir=0.
- **Saturation:**
  - u_in=25: steady pwm_a=1 for all 10 cycles, sat=1.
  - u_in=−32768: pwm_b=1 for all 10 cycles, dir=1, sat=1, no overflow.
- **Reversal:** u_in changes 6 → −3 at cnt=5.
  - Current period still has pwm_a=1 for cnt0–5.
  - Next period: cnt0–1 both low; cnt2 pwm_b=1; cnt3–9 low.
  - pwm_a and pwm_b never high together.
- **Zero effort:** u_in=0 → both legs low for the whole period, dir=0, sat=0. Same direction after zero means no DEAD entry.
- **Enable drop:** enable=0 at cnt=5.
  - Next cycle: both legs 0, cnt 0, no tick.
  - Re-enable: period starts with 2 dead cycles.
- **Mid-run reset:** reset pulse at cnt=7 with enable=1.
  - Next cycle: all outputs 0.
  - After release: DEAD then RUN with the freshly loaded duty.
